// File: rtl/sync_fifo_reader_pkg.sv
// sync_fifo_reader_pkg: shared types, widths and the occupancy next-state rule for sync_fifo_reader.
package sync_fifo_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_state_e;

    localparam int BeatCntWidth = 32;

    // Occupancy after one cycle given a push (p) and a downstream handshake (h).
    function automatic rd_state_e next_state(rd_state_e s, logic p, logic h);
        return (s == EMPTY) ? (p ? ONE : EMPTY) :
               (s == ONE)   ? ((p && !h) ? TWO : (!p && h) ? EMPTY : ONE) :
                              (h ? ONE : TWO);
    endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// stream_skid_buf2: 2-entry registered output buffer; valid and data come straight from flops.
module stream_skid_buf2
    import sync_fifo_reader_pkg::*;
#(
    parameter int WordWidth = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [WordWidth-1:0] push_data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [WordWidth-1:0] data_o,
    output logic                 full_o
);

    rd_state_e            state_q, state_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 hs;
    logic [WordWidth-1:0] mem_q [2];

    assign valid_o = (state_q != EMPTY);
    assign full_o  = (state_q == TWO);
    assign data_o  = mem_q[rd_ptr_q];
    assign hs      = valid_o & ready_i;

    // Flush empties the buffer and rewinds both pointers, overriding push and handshake.
    always_comb begin
        state_d  = flush_i ? EMPTY : next_state(state_q, push_i, hs);
        rd_ptr_d = flush_i ? 1'b0 : rd_ptr_q ^ hs;
        wr_ptr_d = flush_i ? 1'b0 : wr_ptr_q ^ push_i;
    end

    // Occupancy and pointers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload entries carry no reset; each is written only when a push targets it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: drains a FIFO into a valid/ready stream through a 2-entry registered buffer.
// Optional beat counter port beat_cnt_o is built only when SYNC_FIFO_READER_PERF_EN is defined.
module sync_fifo_reader
    import sync_fifo_reader_pkg::*;
#(
    parameter int WordWidth = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    fifo_empty_i,
    input  logic [WordWidth-1:0]    fifo_payload_i,
    output logic                    fifo_pop_o,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    output logic [WordWidth-1:0]    out_payload_o,
    input  logic                    out_ready_i
`ifdef SYNC_FIFO_READER_PERF_EN
    ,
    output logic [BeatCntWidth-1:0] beat_cnt_o
`endif
);

    logic full;

    // Pop depends only on registered occupancy and FIFO/flush flags, never on out_ready_i.
    assign fifo_pop_o = ~fifo_empty_i & ~flush_i & ~full;

    stream_skid_buf2 #(
        .WordWidth(WordWidth)
    ) u_buf (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush_i),
        .push_i     (fifo_pop_o),
        .push_data_i(fifo_payload_i),
        .ready_i    (out_ready_i),
        .valid_o    (out_valid_o),
        .data_o     (out_payload_o),
        .full_o     (full)
    );

`ifdef SYNC_FIFO_READER_PERF_EN
    logic [BeatCntWidth-1:0] beat_cnt_q;

    assign beat_cnt_o = beat_cnt_q;

    // Accepted-beat counter; wraps naturally and survives flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) beat_cnt_q <= '0;
        else if (out_valid_o && out_ready_i) beat_cnt_q <= beat_cnt_q + 1'b1;
    end
`endif

`ifndef SYNTHESIS
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rstn)
        fifo_pop_o |-> ~fifo_empty_i);
    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid_o && !out_ready_i && !flush_i) |=> out_valid_o && $stable(out_payload_o));
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader: randomized and directed checks of sync_fifo_reader against a queue-based model.
module tb_sync_fifo_reader;
    import sync_fifo_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [63:0] fifo_payload_i = '0;
    logic        fifo_pop_o;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic [63:0] out_payload_o;
    logic        out_ready_i = 1'b0;
`ifdef SYNC_FIFO_READER_PERF_EN
    logic [31:0] beat_cnt_o;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int pops = 0;
    int model_beats = 0;
    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] beats_log[$];

    sync_fifo_reader #(.WordWidth(64)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_payload_i(fifo_payload_i),
        .fifo_pop_o    (fifo_pop_o),
        .flush_i       (flush_i),
        .out_valid_o   (out_valid_o),
        .out_payload_o (out_payload_o),
        .out_ready_i   (out_ready_i)
`ifdef SYNC_FIFO_READER_PERF_EN
        ,
        .beat_cnt_o    (beat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive_fifo();
        fifo_empty_i   = (fifo_q.size() == 0);
        fifo_payload_i = (fifo_q.size() != 0) ? fifo_q[0] : 64'h0;
    endtask

    task automatic push(input logic [63:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: sample mid-cycle, compare with the model, then advance model and FIFO after the edge.
    task automatic step();
        logic exp_valid, exp_pop, hs;
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        exp_pop   = (fifo_q.size() != 0) && !flush_i && (exp_q.size() < 2);
        hs        = exp_valid && out_ready_i;
        n_checks++;
        if (out_valid_o !== exp_valid) begin
            n_fail++;
            $display("FAIL valid: got %b want %b at %0t", out_valid_o, exp_valid, $time);
        end
        n_checks++;
        if (fifo_pop_o !== exp_pop) begin
            n_fail++;
            $display("FAIL pop: got %b want %b at %0t", fifo_pop_o, exp_pop, $time);
        end
        if (exp_valid) begin
            n_checks++;
            if (out_payload_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL payload: got %h want %h at %0t", out_payload_o, exp_q[0], $time);
            end
        end
`ifdef SYNC_FIFO_READER_PERF_EN
        n_checks++;
        if (beat_cnt_o !== model_beats[31:0]) begin
            n_fail++;
            $display("FAIL beat_cnt: got %0d want %0d at %0t", beat_cnt_o, model_beats, $time);
        end
`endif
        if (hs) begin
            beats_log.push_back(out_payload_o);
            model_beats++;
        end
        if (exp_pop) pops++;
        @(posedge clk);
        #1;
        if (hs) void'(exp_q.pop_front());
        if (flush_i) begin
            exp_q.delete();
            fifo_q.delete();
        end else if (exp_pop) begin
            exp_q.push_back(fifo_q.pop_front());
        end
        drive_fifo();
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", out_valid_o);
        end
        n_checks++;
        if (fifo_pop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pop: got %b want 0", fifo_pop_o);
        end
        n_checks++;
        if (dut.u_buf.state_q !== EMPTY) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", dut.u_buf.state_q);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_stream();
        logic [63:0] w [3];
        w[0] = 64'h11; w[1] = 64'h22; w[2] = 64'h33;
        beats_log.delete();
        pops = 0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push(w[i]);
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (dut.u_buf.state_q === TWO) begin
                n_fail++;
                $display("FAIL stream_state: got TWO want not TWO");
            end
        end
        n_checks++;
        if (pops != 3 || beats_log.size() != 3) begin
            n_fail++;
            $display("FAIL stream_count: got pops %0d beats %0d want 3 3", pops, beats_log.size());
        end
        for (int i = 0; i < 3 && i < beats_log.size(); i++) begin
            n_checks++;
            if (beats_log[i] !== w[i]) begin
                n_fail++;
                $display("FAIL stream_order: got %h want %h", beats_log[i], w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] w [5];
        beats_log.delete();
        pops = 0;
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = {$urandom, $urandom};
            push(w[i]);
        end
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (pops != 2 || fifo_pop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pops: got pops %0d pop %b want 2 0", pops, fifo_pop_o);
        end
        n_checks++;
        if (out_payload_o !== w[0]) begin
            n_fail++;
            $display("FAIL bp_hold: got %h want %h", out_payload_o, w[0]);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (beats_log.size() != 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 5", beats_log.size());
        end
        for (int i = 0; i < 5 && i < beats_log.size(); i++) begin
            n_checks++;
            if (beats_log[i] !== w[i]) begin
                n_fail++;
                $display("FAIL bp_order: got %h want %h", beats_log[i], w[i]);
            end
        end
    endtask

    task automatic test_empty();
        pops = 0;
        beats_log.delete();
        for (int i = 0; i < 10; i++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        n_checks++;
        if (pops != 0 || beats_log.size() != 0) begin
            n_fail++;
            $display("FAIL empty_idle: got pops %0d beats %0d want 0 0", pops, beats_log.size());
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        push(64'hA);
        push(64'hB);
        step();
        step();
        n_checks++;
        if (dut.u_buf.state_q !== TWO) begin
            n_fail++;
            $display("FAIL flush_pre_state: got %0d want 2", dut.u_buf.state_q);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got valid %b pop %b want 0 0", out_valid_o, fifo_pop_o);
        end
        beats_log.delete();
        out_ready_i = 1'b1;
        push(64'hC);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (beats_log.size() != 1 || beats_log[0] !== 64'hC) begin
            n_fail++;
            $display("FAIL flush_refill: got %0d beats first %h want 1 beat 0xc",
                     beats_log.size(), beats_log.size() ? beats_log[0] : 64'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) push({$urandom, $urandom});
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) push({$urandom, $urandom});
        step();
        step();
        #3;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_valid: got %b want 0", out_valid_o);
        end
        n_checks++;
        if (dut.u_buf.state_q !== EMPTY) begin
            n_fail++;
            $display("FAIL areset_state: got %0d want 0", dut.u_buf.state_q);
        end
        fifo_q.delete();
        exp_q.delete();
        model_beats = 0;
        drive_fifo();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

`ifdef SYNC_FIFO_READER_PERF_EN
    task automatic test_perf();
        beats_log.delete();
        out_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) push({$urandom, $urandom});
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if (beats_log.size() != 7 || beat_cnt_o !== 32'd7) begin
            n_fail++;
            $display("FAIL perf_count: got beats %0d cnt %0d want 7 7", beats_log.size(), beat_cnt_o);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        n_checks++;
        if (beat_cnt_o !== 32'd7) begin
            n_fail++;
            $display("FAIL perf_after_flush: got %0d want 7", beat_cnt_o);
        end
    endtask
`endif

    initial begin
        drive_fifo();
        test_reset();
        test_stream();
        test_backpressure();
        test_empty();
        test_flush();
        test_random();
        test_async_reset();
`ifdef SYNC_FIFO_READER_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_reader.md
# sync_fifo_reader

Consumer-side companion to the synchronous FIFO: drains a FIFO through its pop/empty/head-payload interface and presents the words as a valid/ready stream. Internally it is a registered 2-entry output buffer, so `out_valid_o` and `out_payload_o` come straight from flops. There is no combinational path from `out_ready_i` to `fifo_pop_o`. Sustained throughput is one word per cycle. It sits between any SyncFIFO instance and a downstream pipeline stage or NoC egress.

## Interface
- `WordWidth`, 64, payload width; must match the attached FIFO.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `fifo_empty_i` input 1: FIFO empty flag.
- `fifo_payload_i` input WordWidth: FIFO head word. Combinational from FIFO state and valid whenever `fifo_empty_i`=0.
- `fifo_pop_o` output 1: pop strobe to FIFO.
- `flush_i` input 1: synchronous flush. The parent drives the same signal to the FIFO's flush.
- `out_valid_o` output 1: output word valid.
- `out_payload_o` output WordWidth: output word.
- `out_ready_i` input 1: downstream accepts the word.
- `beat_cnt_o` output 32: accepted-beat counter. Present only with `SYNC_FIFO_READER_PERF_EN`.

## Operation
- Buffer storage:
  - Two entries, `buf[0..1]`.
  - 1-bit read pointer `rd_ptr` and 1-bit write pointer `wr_ptr`, each wrapping 1→0.
  - Occupancy state: EMPTY(0), ONE(1), TWO(2).
- Pop rule: `fifo_pop_o = ~fifo_empty_i & ~flush_i & (state != TWO)`. This is a function of registered state and FIFO flags only, never of `out_ready_i`.
- Outputs:
  - `out_valid_o = (state != EMPTY)`.
  - `out_payload_o = buf[rd_ptr]`.
- On a pop: `buf[wr_ptr] <= fifo_payload_i` and `wr_ptr` increments.
- On a handshake (`out_valid_o & out_ready_i`): `rd_ptr` increments.
- State transitions, where P = pop and H = handshake:
  - EMPTY: P → ONE; otherwise stay.
  - ONE: P&~H → TWO; ~P&H → EMPTY; P&H or ~P&~H → stay.
  - TWO: H → ONE; otherwise stay. P is always 0 in TWO.
- Flush takes priority over everything:
  - Next state is EMPTY, and both `rd_ptr` and `wr_ptr` go to 0.
  - `fifo_pop_o` is 0 in the flush cycle.
  - A handshake in the flush cycle is still accepted by downstream. The buffered word is discarded with the rest.
- Ordering: words leave in exactly FIFO order. No word is duplicated or dropped except by flush.
- Payload entries have no reset and are written only on a pop.
- Outside SYNTHESIS:
  - Assert `fifo_pop_o |-> ~fifo_empty_i`.
  - Assert `out_valid_o & ~out_ready_i |=> out_valid_o && $stable(out_payload_o)`, unless flush is asserted.

## Timing
- Reset values:
  - state EMPTY, `rd_ptr`=`wr_ptr`=0.
  - `out_valid_o`=0, `fifo_pop_o`=0 while FIFO is empty.
  - `out_payload_o` undefined (X allowed), `beat_cnt_o`=0.
- Latency: `fifo_empty_i` falls in cycle N → `fifo_pop_o`=1 in cycle N → `out_valid_o`=1 in cycle N+1.
- Throughput: with `out_ready_i` held at 1 and the FIFO non-empty, state stays ONE and one beat is delivered per cycle.
- Backpressure:
  - With `out_ready_i`=0, the block pops at most 2 words and then holds `fifo_pop_o`=0.
  - Releasing ready gives a beat in that same cycle, and pop resumes the cycle after.
- Reset mid-operation: all state is cleared asynchronously and buffered words are lost. The FIFO must be reset or flushed with it.

## Configuration
- `SYNC_FIFO_READER_PERF_EN` defined:
  - Adds `beat_cnt_o`, which increments by 1 on every handshake and wraps 0xFFFF_FFFF→0.
  - Cleared only by reset, not by flush.
- Not defined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- Package `sync_fifo_reader_pkg` holds:
  - typedef enum logic [1:0] `rd_state_e` {EMPTY=0, ONE=1, TWO=2}.
  - localparam `BeatCntWidth` = 32.
- State and pointers use the existing DFFRE cell. Payload entries use DFFE with per-entry enable.
- One sub-module is natural: `stream_skid_buf2`, the 2-entry buffer with pointers and state. The top level adds pop generation, flush and the perf counter.

## Test plan
- Stream, FIFO preloaded with 0x11,0x22,0x33, ready=1:
  - Pop in cycles 0–2.
  - Valid in cycles 1–3 with payloads 0x11,0x22,0x33.
  - State never reaches TWO.
- Backpressure, FIFO holding 5 words, ready=0 for 6 cycles:
  - Exactly 2 pops, after which pop=0.
  - Payload is held stable at word 0.
  - On releasing ready, all 5 words arrive in order.
- Empty FIFO for 10 cycles: pop=0 and valid=0 throughout. The no-pop-when-empty assertion never fires.
- Flush in state TWO (buffer 0xA,0xB, ready=0):
  - Valid=0 and pop=0 the next cycle.
  - After the FIFO is refilled with 0xC, the first output is 0xC.
- Async reset asserted mid-stream at a non-clock-aligned time: valid drops immediately and state goes to EMPTY.
- With `SYNC_FIFO_READER_PERF_EN`, 7 handshakes then a flush: `beat_cnt_o`=7 and stays 7 after the flush.
